// File: rtl/tmds_video_sequencer_if.sv
// Encoder-facing bundle of the TMDS video sequencer: data enable, per-channel
// control pairs, guard-band select and the look-ahead pixel request.
interface tmds_video_sequencer_if;
  logic        de;
  logic [1:0]  ch0_ctrl;
  logic [1:0]  ch1_ctrl;
  logic [1:0]  ch2_ctrl;
  logic        vgb;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        sof;

  modport master (
    output de, ch0_ctrl, ch1_ctrl, ch2_ctrl, vgb, pix_req, pix_x, pix_y, sof
  );

  modport slave (
    input de, ch0_ctrl, ch1_ctrl, ch2_ctrl, vgb, pix_req, pix_x, pix_y, sof
  );
endinterface

// File: rtl/tmds_video_sequencer.sv
// Video timing generator driving three TMDS encoders, with optional HDMI video
// preamble and leading guard band ahead of every active line.
module tmds_video_sequencer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int HDMI_MODE = 1
) (
  input  logic clk,
  input  logic reset,
  tmds_video_sequencer_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] L_HACT      = 12'(H_ACTIVE);
  localparam logic [11:0] L_HACT_M1   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] L_FRONT_END = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] L_SYNC_END  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] L_PRE_M1    = 12'(H_TOTAL - 11);
  localparam logic [11:0] L_PRE_END   = 12'(H_TOTAL - 3);
  localparam logic [11:0] L_HTOT_M1   = 12'(H_TOTAL - 1);
  localparam logic [11:0] L_VACT      = 12'(V_ACTIVE);
  localparam logic [11:0] L_VACT_M1   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] L_VTOT_M1   = 12'(V_TOTAL - 1);
  localparam logic [11:0] L_VS_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] L_VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        L_HPOL      = 1'(HSYNC_POL);
  localparam logic        L_VPOL      = 1'(VSYNC_POL);
  localparam logic        L_HDMI      = (HDMI_MODE != 0);
  localparam logic        L_BP_TIGHT  = (H_BP == 10);

  typedef enum logic [2:0] {
    S_ACTIVE, S_FRONT, S_SYNC, S_BACK, S_PREAMBLE, S_GUARD
  } state_t;

  state_t      r_state, w_nextState;
  logic [11:0] r_h, r_v;
  logic [11:0] w_nh, w_nv, w_nnh, w_nnv;
  logic        w_preLine, w_nextPixReq;

  logic        r_de, r_hsync, r_vsync, r_vgb, r_pixReq, r_sof;
  logic [1:0]  r_ch1;
  logic [11:0] r_pixX, r_pixY;

  // r_h/r_v is the position currently on the outputs; the outputs are
  // registered from the successor, and pix_req looks one position further.
  always_comb begin
    w_nh  = (r_h == L_HTOT_M1) ? 12'd0 : r_h + 12'd1;
    w_nv  = r_v;
    if (r_h == L_HTOT_M1) w_nv = (r_v == L_VTOT_M1) ? 12'd0 : r_v + 12'd1;
    w_nnh = (w_nh == L_HTOT_M1) ? 12'd0 : w_nh + 12'd1;
    w_nnv = w_nv;
    if (w_nh == L_HTOT_M1) w_nnv = (w_nv == L_VTOT_M1) ? 12'd0 : w_nv + 12'd1;
    w_nextPixReq = (w_nnh < L_HACT) && (w_nnv < L_VACT);
    w_preLine    = L_HDMI && ((r_v == L_VTOT_M1) || (r_v < L_VACT_M1));
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_ACTIVE:   if (r_h == L_HACT_M1) w_nextState = S_FRONT;
      S_FRONT:    if (r_h == L_FRONT_END) w_nextState = S_SYNC;
      S_SYNC:
        if (r_h == L_SYNC_END)
          w_nextState = (w_preLine && L_BP_TIGHT) ? S_PREAMBLE : S_BACK;
      S_BACK:
        if (w_preLine && (r_h == L_PRE_M1)) w_nextState = S_PREAMBLE;
        else if (r_h == L_HTOT_M1)          w_nextState = S_ACTIVE;
      S_PREAMBLE: if (r_h == L_PRE_END) w_nextState = S_GUARD;
      S_GUARD:    if (r_h == L_HTOT_M1) w_nextState = S_ACTIVE;
      default:    w_nextState = S_FRONT;
    endcase
  end

  // Reset parks the counters at the start of FRONT on the last line so the
  // first line after release always gets a complete preamble and guard band.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FRONT;
      r_h      <= L_HACT;
      r_v      <= L_VTOT_M1;
      r_de     <= 1'b0;
      r_hsync  <= ~L_HPOL;
      r_vsync  <= ~L_VPOL;
      r_ch1    <= 2'b00;
      r_vgb    <= 1'b0;
      r_pixReq <= 1'b0;
      r_pixX   <= 12'd0;
      r_pixY   <= 12'd0;
      r_sof    <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_h      <= w_nh;
      r_v      <= w_nv;
      r_de     <= (w_nextState == S_ACTIVE) && (w_nv < L_VACT);
      r_hsync  <= (w_nextState == S_SYNC) ? L_HPOL : ~L_HPOL;
      r_vsync  <= ((w_nv >= L_VS_START) && (w_nv < L_VS_END)) ? L_VPOL : ~L_VPOL;
      r_ch1    <= (w_nextState == S_PREAMBLE) ? 2'b01 : 2'b00;
      r_vgb    <= (w_nextState == S_GUARD);
      r_pixReq <= w_nextPixReq;
      if (w_nextPixReq) begin
        r_pixX <= w_nnh;
        r_pixY <= w_nnv;
      end
      r_sof    <= (w_nextState == S_ACTIVE) && (w_nh == 12'd0) && (w_nv == 12'd0);
    end
  end

  assign bus.de       = r_de;
  assign bus.ch0_ctrl = {r_vsync, r_hsync};
  assign bus.ch1_ctrl = r_ch1;
  assign bus.ch2_ctrl = 2'b00;
  assign bus.vgb      = r_vgb;
  assign bus.pix_req  = r_pixReq;
  assign bus.pix_x    = r_pixX;
  assign bus.pix_y    = r_pixY;
  assign bus.sof      = r_sof;

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Self-checking bench: an HDMI and a DVI sequencer run side by side against a
// position-based reference model, with randomized reset points.
module tb_tmds_video_sequencer;
  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 12;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [33:0] RESET_VEC = {1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  int mh, mv;
  logic [11:0] lastX, lastY;
  logic [33:0] expHdmi, expDvi;
  logic [33:0] obsHdmi, obsDvi;

  always #5 clk = ~clk;

  tmds_video_sequencer_if hdmiBus();
  tmds_video_sequencer_if dviBus();

  tmds_video_sequencer #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(0), .VSYNC_POL(0), .HDMI_MODE(1)
  ) dutHdmi (.clk(clk), .reset(reset), .bus(hdmiBus));

  tmds_video_sequencer #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(0), .VSYNC_POL(0), .HDMI_MODE(0)
  ) dutDvi (.clk(clk), .reset(reset), .bus(dviBus));

  assign obsHdmi = {hdmiBus.de, hdmiBus.ch0_ctrl, hdmiBus.ch1_ctrl, hdmiBus.ch2_ctrl,
                    hdmiBus.vgb, hdmiBus.pix_req, hdmiBus.pix_x, hdmiBus.pix_y, hdmiBus.sof};
  assign obsDvi  = {dviBus.de, dviBus.ch0_ctrl, dviBus.ch1_ctrl, dviBus.ch2_ctrl,
                    dviBus.vgb, dviBus.pix_req, dviBus.pix_x, dviBus.pix_y, dviBus.sof};

  // Expected encoder signals for raster position (h, v), straight from the timing rules.
  function automatic logic [33:0] modelOut(int h, int v, bit hdmi, bit preq,
                                           logic [11:0] px, logic [11:0] py);
    bit nextAct = (((v + 1) % V_TOTAL) < V_ACTIVE);
    bit pre = hdmi && nextAct && (h >= H_TOTAL - 10) && (h <= H_TOTAL - 3);
    bit grd = hdmi && nextAct && (h >= H_TOTAL - 2);
    bit de  = (h < H_ACTIVE) && (v < V_ACTIVE) && !grd;
    bit hs  = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    bit vs  = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    bit sof = (h == 0) && (v == 0);
    return {de, vs, hs, 1'b0, pre, 2'b00, grd, preq, px, py, sof};
  endfunction

  // Advance one clock: update the model position and expectations, then wait
  // for the falling edge so outputs are sampled away from the active edge.
  task automatic step();
    int nh, nv;
    bit preq;
    @(posedge clk);
    if (reset) begin
      mh = H_ACTIVE;
      mv = V_TOTAL - 1;
      lastX = 12'd0;
      lastY = 12'd0;
      expHdmi = RESET_VEC;
      expDvi  = RESET_VEC;
    end else begin
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv = (mv + 1) % V_TOTAL;
      end
      nh = mh + 1;
      nv = mv;
      if (nh == H_TOTAL) begin
        nh = 0;
        nv = (mv + 1) % V_TOTAL;
      end
      preq = (nh < H_ACTIVE) && (nv < V_ACTIVE);
      if (preq) begin
        lastX = 12'(nh);
        lastY = 12'(nv);
      end
      expHdmi = modelOut(mh, mv, 1'b1, preq, lastX, lastY);
      expDvi  = modelOut(mh, mv, 1'b0, preq, lastX, lastY);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({obsHdmi, obsDvi} !== {expHdmi, expDvi}) begin
        errors++;
        $display("[TB] FAIL reset_values cycle %0d: got hdmi=%h dvi=%h required %h", i, obsHdmi, obsDvi, expHdmi);
      end
    end
  endtask

  task automatic test_first_line();
    int sofCycle = -1;
    int preCount = 0;
    int vgbCount = 0;
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if ({obsHdmi, obsDvi} !== {expHdmi, expDvi}) begin
        errors++;
        $display("[TB] FAIL first_line at (%0d,%0d): got hdmi=%h dvi=%h required hdmi=%h dvi=%h",
                 mh, mv, obsHdmi, obsDvi, expHdmi, expDvi);
      end
      if (hdmiBus.ch1_ctrl == 2'b01) preCount++;
      if (hdmiBus.vgb) vgbCount++;
      if (hdmiBus.sof) begin
        sofCycle = i;
        break;
      end
    end
    checks++;
    if (sofCycle != H_TOTAL - H_ACTIVE) begin
      errors++;
      $display("[TB] FAIL first_sof_latency: got %0d required %0d", sofCycle, H_TOTAL - H_ACTIVE);
    end
    checks++;
    if (preCount != 8 || vgbCount != 2) begin
      errors++;
      $display("[TB] FAIL first_preamble: got preamble=%0d guard=%0d required 8 and 2", preCount, vgbCount);
    end
  endtask

  task automatic test_frames();
    int deCount = 0;
    int sofCount = 0;
    int overlap = 0;
    int dviCtl = 0;
    for (int i = 0; i < 3 * H_TOTAL * V_TOTAL; i++) begin
      step();
      checks++;
      if ({obsHdmi, obsDvi} !== {expHdmi, expDvi}) begin
        errors++;
        $display("[TB] FAIL frames at (%0d,%0d): got hdmi=%h dvi=%h required hdmi=%h dvi=%h",
                 mh, mv, obsHdmi, obsDvi, expHdmi, expDvi);
      end
      if (hdmiBus.de) deCount++;
      if (hdmiBus.sof) sofCount++;
      if (hdmiBus.de && hdmiBus.vgb) overlap++;
      if (dviBus.ch1_ctrl != 2'b00 || dviBus.ch2_ctrl != 2'b00 || dviBus.vgb) dviCtl++;
    end
    checks++;
    if (deCount != 3 * H_ACTIVE * V_ACTIVE || sofCount != 3) begin
      errors++;
      $display("[TB] FAIL frame_counts: got de=%0d sof=%0d required %0d and 3", deCount, sofCount, 3 * H_ACTIVE * V_ACTIVE);
    end
    checks++;
    if (overlap != 0 || dviCtl != 0) begin
      errors++;
      $display("[TB] FAIL exclusivity: got de_vgb=%0d dvi_ctl=%0d required 0 and 0", overlap, dviCtl);
    end
  endtask

  task automatic test_mid_preamble_reset();
    bit found = 0;
    int firstDe = -1;
    for (int i = 0; i < 300; i++) begin
      if (mh == 17 && mv == 2) begin
        found = 1;
        break;
      end
      step();
      checks++;
      if ({obsHdmi, obsDvi} !== {expHdmi, expDvi}) begin
        errors++;
        $display("[TB] FAIL pre_reset_run at (%0d,%0d): got hdmi=%h dvi=%h required hdmi=%h dvi=%h",
                 mh, mv, obsHdmi, obsDvi, expHdmi, expDvi);
      end
    end
    checks++;
    if (!found || hdmiBus.ch1_ctrl !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reach_preamble: got found=%0d ch1=%b required 1 and 01", found, hdmiBus.ch1_ctrl);
    end
    reset = 1'b1;
    repeat ($urandom_range(1, 3)) begin
      step();
      checks++;
      if ({obsHdmi, obsDvi} !== {RESET_VEC, RESET_VEC}) begin
        errors++;
        $display("[TB] FAIL preamble_abort: got hdmi=%h dvi=%h required %h", obsHdmi, obsDvi, RESET_VEC);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      step();
      checks++;
      if ({obsHdmi, obsDvi} !== {expHdmi, expDvi}) begin
        errors++;
        $display("[TB] FAIL restart at (%0d,%0d): got hdmi=%h dvi=%h required hdmi=%h dvi=%h",
                 mh, mv, obsHdmi, obsDvi, expHdmi, expDvi);
      end
      if (hdmiBus.de) begin
        firstDe = i;
        break;
      end
    end
    checks++;
    if (firstDe != H_TOTAL - H_ACTIVE || mv != 0) begin
      errors++;
      $display("[TB] FAIL restart_first_de: got cycle=%0d line=%0d required %0d and 0", firstDe, mv, H_TOTAL - H_ACTIVE);
    end
  endtask

  task automatic test_random_reset();
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 300)) begin
        step();
        checks++;
        if ({obsHdmi, obsDvi} !== {expHdmi, expDvi}) begin
          errors++;
          $display("[TB] FAIL random_run at (%0d,%0d): got hdmi=%h dvi=%h required hdmi=%h dvi=%h",
                   mh, mv, obsHdmi, obsDvi, expHdmi, expDvi);
        end
      end
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        step();
        checks++;
        if ({obsHdmi, obsDvi} !== {expHdmi, expDvi}) begin
          errors++;
          $display("[TB] FAIL random_reset: got hdmi=%h dvi=%h required %h", obsHdmi, obsDvi, expHdmi);
        end
      end
      reset = 1'b0;
    end
    repeat (H_TOTAL * V_TOTAL) begin
      step();
      checks++;
      if ({obsHdmi, obsDvi} !== {expHdmi, expDvi}) begin
        errors++;
        $display("[TB] FAIL random_tail at (%0d,%0d): got hdmi=%h dvi=%h required hdmi=%h dvi=%h",
                 mh, mv, obsHdmi, obsDvi, expHdmi, expDvi);
      end
    end
  endtask

  initial begin
    $display("[TB] tmds_video_sequencer bench starting");
    test_reset();
    test_first_line();
    test_frames();
    test_mid_preamble_reset();
    test_random_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
